// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and helpers for the unified memory port arbiter.
//   - arb_state_e : owner of the single outstanding transaction
//   - cnt_width() : width needed for a counter that saturates at a given value
package mem_port_arbiter_pkg;

    // The encodings are fixed so that they line up with the core's debug view of the arbiter.
    typedef enum logic [1:0] {
        ArbIdle = 2'b00,
        ArbIf   = 2'b01,
        ArbLsu  = 2'b10
    } arb_state_e;

    // Width of a counter that must hold every value from 0 up to max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch, load/store and memory-side signals of the arbiter.
//   Signals:
//     if_*   : fetch request (valid/addr/ready) and response (valid/data)
//     lsu_*  : load/store request (valid/we/addr/wdata/wmask/ready) and response
//     mem_*  : muxed request towards memory and its response
//     busy_out / err_out : status
//   Modports:
//     slave  : the arbiter itself (serves the core requesters, drives memory)
//     master : the environment (fetch unit, LSU and memory model)
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  if_req_valid_in;
    logic [ADDR_W-1:0]     if_addr_in;
    logic                  if_req_ready_out;
    logic                  if_rsp_valid_out;
    logic [DATA_W-1:0]     if_rsp_data_out;

    logic                  lsu_req_valid_in;
    logic                  lsu_we_in;
    logic [ADDR_W-1:0]     lsu_addr_in;
    logic [DATA_W-1:0]     lsu_wdata_in;
    logic [DATA_W/8-1:0]   lsu_wmask_in;
    logic                  lsu_req_ready_out;
    logic                  lsu_rsp_valid_out;
    logic [DATA_W-1:0]     lsu_rsp_data_out;

    logic                  mem_req_valid_out;
    logic                  mem_req_ready_in;
    logic                  mem_we_out;
    logic [ADDR_W-1:0]     mem_addr_out;
    logic [DATA_W-1:0]     mem_wdata_out;
    logic [DATA_W/8-1:0]   mem_wmask_out;
    logic                  mem_rsp_valid_in;
    logic [DATA_W-1:0]     mem_rsp_data_in;

    logic                  busy_out;
    logic                  err_out;

    modport slave (
        input  if_req_valid_in, if_addr_in,
        output if_req_ready_out, if_rsp_valid_out, if_rsp_data_out,
        input  lsu_req_valid_in, lsu_we_in, lsu_addr_in, lsu_wdata_in, lsu_wmask_in,
        output lsu_req_ready_out, lsu_rsp_valid_out, lsu_rsp_data_out,
        output mem_req_valid_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wmask_out,
        input  mem_req_ready_in, mem_rsp_valid_in, mem_rsp_data_in,
        output busy_out, err_out
    );

    modport master (
        output if_req_valid_in, if_addr_in,
        input  if_req_ready_out, if_rsp_valid_out, if_rsp_data_out,
        output lsu_req_valid_in, lsu_we_in, lsu_addr_in, lsu_wdata_in, lsu_wmask_in,
        input  lsu_req_ready_out, lsu_rsp_valid_out, lsu_rsp_data_out,
        input  mem_req_valid_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wmask_out,
        output mem_req_ready_in, mem_rsp_valid_in, mem_rsp_data_in,
        input  busy_out, err_out
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and the load/store unit. Only one
//   transaction is outstanding at a time. The LSU wins by default; after STARVE_MAX
//   consecutive LSU grants while fetch was waiting, fetch is forced to win once.
//   Ports:
//     clk  : clock, all state updates on the rising edge
//     rst  : synchronous active-high reset (drops any in-flight transaction)
//     bus  : mem_port_arbiter_if.slave, fetch/LSU request+response and memory port
//   Parameters:
//     ADDR_W, DATA_W : address and data width
//     STARVE_MAX     : LSU grants with fetch pending before fetch is forced (>= 1)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned     CntW      = cnt_width(STARVE_MAX);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            err_q, err_d;

    logic            win_if;
    logic            win_lsu;
    logic            starved;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ArbIdle;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

    // Winner selection; only acted upon in the idle state.
    always_comb begin
        starved = bus.if_req_valid_in && (starve_cnt_q == StarveMax);
        win_lsu = bus.lsu_req_valid_in && !starved;
        win_if  = !win_lsu && bus.if_req_valid_in;
    end

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        err_d         = err_q;

        bus.mem_req_valid_out = 1'b0;
        bus.mem_we_out        = 1'b0;
        bus.mem_addr_out      = '0;
        bus.mem_wdata_out     = '0;
        bus.mem_wmask_out     = '0;
        bus.if_req_ready_out  = 1'b0;
        bus.lsu_req_ready_out = 1'b0;
        bus.if_rsp_valid_out  = 1'b0;
        bus.lsu_rsp_valid_out = 1'b0;

        case (state_q)
            ArbIdle: begin
                // Nothing is outstanding, so any response here is a protocol violation.
                if (bus.mem_rsp_valid_in) begin
                    err_d = 1'b1;
                end

                if (win_lsu) begin
                    bus.mem_req_valid_out = 1'b1;
                    bus.mem_we_out        = bus.lsu_we_in;
                    bus.mem_addr_out      = bus.lsu_addr_in;
                    bus.mem_wdata_out     = bus.lsu_wdata_in;
                    bus.mem_wmask_out     = bus.lsu_wmask_in;
                    bus.lsu_req_ready_out = bus.mem_req_ready_in;
                    if (bus.mem_req_ready_in) begin
                        state_d = ArbLsu;
                        // Count only grants that made fetch wait; saturation is defensive.
                        if (bus.if_req_valid_in) begin
                            if (starve_cnt_q != StarveMax) begin
                                starve_cnt_d = starve_cnt_q + 1'b1;
                            end
                        end else begin
                            starve_cnt_d = '0;
                        end
                    end
                end else if (win_if) begin
                    bus.mem_req_valid_out = 1'b1;
                    bus.mem_addr_out      = bus.if_addr_in;
                    bus.if_req_ready_out  = bus.mem_req_ready_in;
                    if (bus.mem_req_ready_in) begin
                        state_d      = ArbIf;
                        starve_cnt_d = '0;
                    end
                end
            end

            ArbIf: begin
                if (bus.mem_rsp_valid_in) begin
                    bus.if_rsp_valid_out = 1'b1;
                    state_d              = ArbIdle;
                end
            end

            ArbLsu: begin
                if (bus.mem_rsp_valid_in) begin
                    bus.lsu_rsp_valid_out = 1'b1;
                    state_d               = ArbIdle;
                end
            end

            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    // Data is broadcast to both requesters; only the valids carry ownership.
    assign bus.if_rsp_data_out  = bus.mem_rsp_data_in;
    assign bus.lsu_rsp_data_out = bus.mem_rsp_data_in;

    assign bus.busy_out = (state_q != ArbIdle);
    assign bus.err_out  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Expected grants and responses are queued when the
//   stimulus is issued; a negedge monitor pops and compares whenever the arbiter hands a
//   request to memory or returns a response. Point checks cover status outputs.
module tb_mem_port_arbiter;

    typedef struct {
        logic        lsu;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } grant_t;

    typedef struct {
        logic        lsu;
        logic [31:0] data;
    } rsp_t;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    grant_t grant_q[$];
    rsp_t   rsp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    // Memory/requester behaviour knobs used by cyc().
    logic        auto_rsp    = 1'b0;
    logic        if_persist  = 1'b0;
    logic        lsu_persist = 1'b0;
    logic [31:0] if_rdata    = '0;
    logic [31:0] lsu_rdata   = '0;

    grant_t mon_g;
    rsp_t   mon_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic grant_t mk_grant(input logic lsu, input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] wmask);
        grant_t g;
        g.lsu = lsu; g.we = we; g.addr = addr; g.wdata = wdata; g.wmask = wmask;
        return g;
    endfunction

    function automatic rsp_t mk_rsp(input logic lsu, input logic [31:0] data);
        rsp_t r;
        r.lsu = lsu; r.data = data;
        return r;
    endfunction

    // Advance one clock. Accepted requests are retired (unless persistent) and, with
    // auto_rsp, memory answers in the following cycle with the owner's read data.
    task automatic cyc();
        logic        hs_if;
        logic        hs_lsu;
        logic [31:0] d;
        hs_if  = bus.mem_req_valid_out && bus.mem_req_ready_in && bus.if_req_ready_out;
        hs_lsu = bus.mem_req_valid_out && bus.mem_req_ready_in && bus.lsu_req_ready_out;
        d      = '0;
        @(posedge clk);
        #1;
        bus.mem_rsp_valid_in = 1'b0;
        if (hs_if) begin
            if (!if_persist) bus.if_req_valid_in = 1'b0;
            d = if_rdata;
        end
        if (hs_lsu) begin
            if (!lsu_persist) bus.lsu_req_valid_in = 1'b0;
            d = lsu_rdata;
        end
        if ((hs_if || hs_lsu) && auto_rsp) begin
            bus.mem_rsp_valid_in = 1'b1;
            bus.mem_rsp_data_in  = d;
        end
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req_valid_out && bus.mem_req_ready_in) begin
                if (grant_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got grant addr %h, expected none (t=%0t)",
                             bus.mem_addr_out, $time);
                end else begin
                    mon_g = grant_q.pop_front();
                    check("grant_one_ready", 32'(bus.if_req_ready_out ^ bus.lsu_req_ready_out), 1);
                    check("grant_owner", 32'(bus.lsu_req_ready_out), 32'(mon_g.lsu));
                    check("grant_we", 32'(bus.mem_we_out), 32'(mon_g.we));
                    check("grant_addr", bus.mem_addr_out, mon_g.addr);
                    check("grant_wdata", bus.mem_wdata_out, mon_g.wdata);
                    check("grant_wmask", 32'(bus.mem_wmask_out), 32'(mon_g.wmask));
                end
            end
            if (bus.if_rsp_valid_out || bus.lsu_rsp_valid_out) begin
                if (rsp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got if=%0b lsu=%0b, expected none (t=%0t)",
                             bus.if_rsp_valid_out, bus.lsu_rsp_valid_out, $time);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rsp_one_valid", 32'(bus.if_rsp_valid_out ^ bus.lsu_rsp_valid_out), 1);
                    check("rsp_owner", 32'(bus.lsu_rsp_valid_out), 32'(mon_r.lsu));
                    check("rsp_data", mon_r.lsu ? bus.lsu_rsp_data_out : bus.if_rsp_data_out,
                          mon_r.data);
                end
            end
        end
    end

    initial begin
        rst                  = 1'b1;
        bus.if_req_valid_in  = 1'b0;
        bus.if_addr_in       = '0;
        bus.lsu_req_valid_in = 1'b0;
        bus.lsu_we_in        = 1'b0;
        bus.lsu_addr_in      = '0;
        bus.lsu_wdata_in     = '0;
        bus.lsu_wmask_in     = '0;
        bus.mem_req_ready_in = 1'b0;
        bus.mem_rsp_valid_in = 1'b0;
        bus.mem_rsp_data_in  = '0;

        // Reset state
        cyc();
        cyc();
        check("rst_busy", 32'(bus.busy_out), 0);
        check("rst_err", 32'(bus.err_out), 0);
        check("rst_mem_valid", 32'(bus.mem_req_valid_out), 0);
        check("rst_readies", 32'({bus.if_req_ready_out, bus.lsu_req_ready_out}), 0);
        check("rst_rsp_valids", 32'({bus.if_rsp_valid_out, bus.lsu_rsp_valid_out}), 0);
        rst = 1'b0;
        cyc();

        // 1: fetch only, single-cycle memory
        auto_rsp             = 1'b1;
        bus.mem_req_ready_in = 1'b1;
        if_rdata             = 32'hDEAD_BEEF;
        bus.if_addr_in       = 32'h0000_0100;
        bus.if_req_valid_in  = 1'b1;
        grant_q.push_back(mk_grant(1'b0, 1'b0, 32'h100, 32'h0, 4'h0));
        rsp_q.push_back(mk_rsp(1'b0, 32'hDEAD_BEEF));
        #1;
        check("t1_if_ready", 32'(bus.if_req_ready_out), 1);
        check("t1_lsu_ready", 32'(bus.lsu_req_ready_out), 0);
        check("t1_busy_t0", 32'(bus.busy_out), 0);
        cyc();
        check("t1_busy_t1", 32'(bus.busy_out), 1);
        check("t1_if_rsp_valid", 32'(bus.if_rsp_valid_out), 1);
        check("t1_if_rsp_data", bus.if_rsp_data_out, 32'hDEAD_BEEF);
        cyc();
        check("t1_busy_t2", 32'(bus.busy_out), 0);

        // 2: fetch and store together; LSU first, fetch at T+2
        if_rdata              = 32'h1111_2222;
        lsu_rdata             = 32'hCAFE_0000;
        bus.if_addr_in        = 32'h0000_0104;
        bus.if_req_valid_in   = 1'b1;
        bus.lsu_we_in         = 1'b1;
        bus.lsu_addr_in       = 32'h0000_2000;
        bus.lsu_wdata_in      = 32'h0000_0055;
        bus.lsu_wmask_in      = 4'b0001;
        bus.lsu_req_valid_in  = 1'b1;
        grant_q.push_back(mk_grant(1'b1, 1'b1, 32'h2000, 32'h55, 4'b0001));
        grant_q.push_back(mk_grant(1'b0, 1'b0, 32'h104, 32'h0, 4'h0));
        rsp_q.push_back(mk_rsp(1'b1, 32'hCAFE_0000));
        rsp_q.push_back(mk_rsp(1'b0, 32'h1111_2222));
        #1;
        check("t2_lsu_ready", 32'(bus.lsu_req_ready_out), 1);
        check("t2_if_ready_t0", 32'(bus.if_req_ready_out), 0);
        check("t2_mem_we", 32'(bus.mem_we_out), 1);
        cyc();
        check("t2_busy_mem_valid", 32'(bus.mem_req_valid_out), 0);
        check("t2_if_ready_t1", 32'(bus.if_req_ready_out), 0);
        check("t2_lsu_rsp_valid", 32'(bus.lsu_rsp_valid_out), 1);
        cyc();
        check("t2_if_ready_t2", 32'(bus.if_req_ready_out), 1);
        cyc();
        cyc();
        check("t2_idle", 32'(bus.busy_out), 0);

        // 3: constant pressure; 4 LSU grants, 1 fetch, counter restarts
        if_persist            = 1'b1;
        lsu_persist           = 1'b1;
        if_rdata              = 32'hA0A0_A0A0;
        lsu_rdata             = 32'h5B5B_5B5B;
        bus.if_addr_in        = 32'h0000_0200;
        bus.lsu_we_in         = 1'b0;
        bus.lsu_addr_in       = 32'h0000_3000;
        bus.lsu_wdata_in      = 32'h0BAD_F00D;
        bus.lsu_wmask_in      = 4'hF;
        bus.if_req_valid_in   = 1'b1;
        bus.lsu_req_valid_in  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                grant_q.push_back(mk_grant(1'b0, 1'b0, 32'h200, 32'h0, 4'h0));
                rsp_q.push_back(mk_rsp(1'b0, 32'hA0A0_A0A0));
            end else begin
                grant_q.push_back(mk_grant(1'b1, 1'b0, 32'h3000, 32'h0BAD_F00D, 4'hF));
                rsp_q.push_back(mk_rsp(1'b1, 32'h5B5B_5B5B));
            end
        end
        #1;
        for (int c = 0; c < 20; c++) begin
            cyc();
        end
        if_persist           = 1'b0;
        lsu_persist          = 1'b0;
        bus.if_req_valid_in  = 1'b0;
        bus.lsu_req_valid_in = 1'b0;
        #1;
        check("t3_pressure_drained", 32'(grant_q.size()), 0);
        cyc();

        // 4: memory stalls the request for three cycles
        bus.mem_req_ready_in = 1'b0;
        lsu_rdata            = 32'h0000_0000;
        bus.lsu_we_in        = 1'b1;
        bus.lsu_addr_in      = 32'h0000_4000;
        bus.lsu_wdata_in     = 32'h1234_5678;
        bus.lsu_wmask_in     = 4'hC;
        bus.lsu_req_valid_in = 1'b1;
        grant_q.push_back(mk_grant(1'b1, 1'b1, 32'h4000, 32'h1234_5678, 4'hC));
        rsp_q.push_back(mk_rsp(1'b1, 32'h0));
        #1;
        for (int c = 0; c < 3; c++) begin
            check("t4_stall_valid", 32'(bus.mem_req_valid_out), 1);
            check("t4_stall_addr", bus.mem_addr_out, 32'h4000);
            check("t4_stall_wdata", bus.mem_wdata_out, 32'h1234_5678);
            check("t4_stall_ready", 32'(bus.lsu_req_ready_out), 0);
            check("t4_stall_busy", 32'(bus.busy_out), 0);
            cyc();
        end
        bus.mem_req_ready_in = 1'b1;
        #1;
        check("t4_ready_4th", 32'(bus.lsu_req_ready_out), 1);
        cyc();
        cyc();
        check("t4_idle", 32'(bus.busy_out), 0);

        // 5: spurious response while idle
        bus.mem_rsp_valid_in = 1'b1;
        bus.mem_rsp_data_in  = 32'h0000_0099;
        #1;
        check("t5_no_rsp", 32'({bus.if_rsp_valid_out, bus.lsu_rsp_valid_out}), 0);
        check("t5_err_before", 32'(bus.err_out), 0);
        cyc();
        check("t5_err_set", 32'(bus.err_out), 1);
        cyc();
        cyc();
        check("t5_err_sticky", 32'(bus.err_out), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("t5_err_cleared", 32'(bus.err_out), 0);

        // 6: reset while the LSU owns the port; the late response only flags an error
        auto_rsp             = 1'b0;
        bus.lsu_we_in        = 1'b0;
        bus.lsu_addr_in      = 32'h0000_5000;
        bus.lsu_req_valid_in = 1'b1;
        grant_q.push_back(mk_grant(1'b1, 1'b0, 32'h5000, 32'h1234_5678, 4'hC));
        #1;
        cyc();
        check("t6_busy_lsu", 32'(bus.busy_out), 1);
        rst = 1'b1;
        #1;
        cyc();
        rst = 1'b0;
        #1;
        check("t6_busy_after_rst", 32'(bus.busy_out), 0);
        bus.mem_rsp_valid_in = 1'b1;
        bus.mem_rsp_data_in  = 32'h0000_0077;
        #1;
        check("t6_late_rsp_dropped", 32'(bus.lsu_rsp_valid_out), 0);
        cyc();
        check("t6_late_rsp_err", 32'(bus.err_out), 1);

        cyc();
        cyc();
        check("end_grants_consumed", 32'(grant_q.size()), 0);
        check("end_rsps_consumed", 32'(rsp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
